rf_debug_dumper: RTL
====================

# rf_debug_dumper

Sequential reader for the register file's debug read port: on command it walks a register index range, samples each register through the asynchronous debug read path, and streams (index, value) beats over a valid/ready interface. It sits between the CPU's register file and the debug/PDU logic, replacing manual single-address polling of the debug port. Scans are not snapshots: a register the core writes mid-scan returns whichever value the debug port shows at its sample cycle.

## Interface
- NUM_REGS, 32, number of architectural registers; index width is 5
- DATA_W, 32, register width
- clk  input  1  single clock, all state on posedge
- rstn  input  1  asynchronous active-low reset
- start  input  1  scan request; accepted only in IDLE
- range_lo  input  5  first index, sampled on accepted start
- range_hi  input  5  last index, sampled on accepted start
- busy  output  1  high in LOAD and SEND
- done  output  1  one-cycle pulse at end of scan
- debug_rf_ra  output  5  debug read address to register file
- debug_rf_rd  input  32  debug read data, combinational from debug_rf_ra
- out_valid  output  1  beat valid
- out_ready  input  1  sink ready
- out_idx  output  5  register index of current beat
- out_data  output  32  register value of current beat
- out_last  output  1  high on final beat of scan

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: start=1 latches lo/hi into internal registers, sets idx=lo. If lo>hi → DONE (empty scan, zero beats), else → LOAD.
- LOAD: debug_rf_ra=idx; capture debug_rf_rd into out_data, idx into out_idx, out_last=(idx==hi_q); → SEND.
- SEND: out_valid=1. Handshake when out_valid&&out_ready. On handshake: if out_last → DONE, else idx=idx+1, → LOAD. Without handshake, out_valid/out_idx/out_data/out_last hold unchanged.
- DONE: done=1 for exactly one cycle; → IDLE.
- start outside IDLE ignored; range_lo/range_hi changes after acceptance have no effect.
- idx never wraps: hi_q ≤ 31 guarantees last beat before overflow.
- debug_rf_ra always equals idx register (driven in every state).
- Reset (async assert, any state): state=IDLE, idx=0, debug_rf_ra=0, busy=0, done=0, out_valid=0, out_idx=0, out_data=0, out_last=0. A scan interrupted by reset is abandoned; no done pulse.

## Timing
- start accepted in cycle N → LOAD in N+1 (busy=1) → out_valid=1 in N+2.
- Per beat: minimum 2 cycles (LOAD + SEND) with out_ready held high.
- Full 32-register scan, out_ready=1: first beat N+2, last beat N+64, done=1 in N+65, IDLE in N+66.
- Empty scan (lo>hi): done=1 in N+1, busy never asserts.
- Sampled value is the register content at the LOAD cycle; a register-file write in the same cycle is not visible (write lands on next edge).
- busy=0 and done=1 never coexist with out_valid=1.

## Configuration
- RF_DUMP_SKIP_ZERO_EN defined: a latched range_lo of 0 is promoted to 1; x0 never appears as a beat. lo=0, hi=0 becomes an empty scan.
- Undefined: x0 is scanned like any other index (value always 0).

## Structure
- Shared package rf_dump_pkg: state enum (IDLE, LOAD, SEND, DONE), RF_IDX_W=5, RF_NUM_REGS=32, RF_LAST_IDX=5'd31.
- Single module; no sub-module is natural (FSM, idx counter and output holding register are each a few lines).

## Test plan
- Registers preloaded x_i=i*32'h11 (x0=0), lo=0, hi=31, out_ready=1, macro undefined → 32 beats idx 0..31, data i*32'h11, out_last only on idx 31, done one cycle after last handshake.
- Same preload, lo=2, hi=6, out_ready dropped for 5 cycles while idx=4 is valid → out_valid, out_idx=4, out_data=32'h44, out_last=0 stable throughout; beats 2..6 delivered in order, none duplicated.
- lo=5, hi=5 → exactly one beat idx=5, data=32'h55, out_last=1; lo=9, hi=3 → no beats, done=1 at N+1, busy stays 0.
- Second start pulsed mid-scan with different range → ignored, original scan completes; rstn pulsed low at beat 3 → all outputs 0 immediately, no done; following start with lo=7, hi=8 yields beats 7, 8.
- Core writes x10=32'hDEAD_BEEF while scan is at idx 4 with lo=0, hi=15 → idx 10 beat returns 32'hDEAD_BEEF.
- RF_DUMP_SKIP_ZERO_EN defined, lo=0, hi=2 → beats idx 1, 2 only; lo=0, hi=0 → zero beats, done pulse at N+1.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg
//   Shared definitions for the register-file debug dumper: scan FSM state
//   encoding, index geometry and the start-index promotion helper.
//
//   Optional feature macro: RF_DUMP_SKIP_ZERO_EN
//     defined   -> a requested first index of 0 is promoted to 1, so x0 is
//                  never streamed (lo=0, hi=0 becomes an empty scan)
//     undefined -> x0 is scanned like every other register
package rf_dump_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_IDX_W    = $clog2(RF_NUM_REGS);
  localparam int RF_DATA_W   = 32;
  localparam logic [RF_IDX_W-1:0] RF_LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rf_dump_state_e;

  // First index actually scanned for a requested range_lo.
  function automatic logic [RF_IDX_W-1:0] effective_lo(input logic [RF_IDX_W-1:0] lo);
`ifdef RF_DUMP_SKIP_ZERO_EN
    return (lo == '0) ? RF_IDX_W'(1) : lo;
`else
    return lo;
`endif
  endfunction

endpackage

// File: rtl/rf_debug_dumper.sv
// rf_debug_dumper
//   Walks a register index range on command, samples each register through
//   the asynchronous debug read port and streams (index, value) beats over a
//   valid/ready interface. Scans are not snapshots: each register is sampled
//   in its own LOAD cycle.
//
//   Optional feature macro: RF_DUMP_SKIP_ZERO_EN (see rf_dump_pkg).
//
//   Ports
//     clk          in   clock, all state on posedge
//     rstn         in   asynchronous active-low reset
//     start        in   scan request, accepted only when idle
//     range_lo     in   [4:0] first index, sampled on accepted start
//     range_hi     in   [4:0] last index, sampled on accepted start
//     busy         out  high while loading/sending beats
//     done         out  one-cycle pulse at end of scan
//     debug_rf_ra  out  [4:0] debug read address to the register file
//     debug_rf_rd  in   [DATA_W-1:0] debug read data (combinational from ra)
//     out_valid    out  beat valid
//     out_ready    in   sink ready
//     out_idx      out  [4:0] register index of current beat
//     out_data     out  [DATA_W-1:0] register value of current beat
//     out_last     out  final beat of the scan
module rf_debug_dumper
  import rf_dump_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [RF_IDX_W-1:0] range_lo,
  input  logic [RF_IDX_W-1:0] range_hi,
  output logic                busy,
  output logic                done,
  output logic [RF_IDX_W-1:0] debug_rf_ra,
  input  logic [DATA_W-1:0]   debug_rf_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RF_IDX_W-1:0] out_idx,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last
);

  rf_dump_state_e      state;
  logic [RF_IDX_W-1:0] idx;
  logic [RF_IDX_W-1:0] hi_q;
  logic [RF_IDX_W-1:0] lo_eff;

  assign lo_eff = effective_lo(range_lo);

  // The read address is the index register itself, so it is defined in
  // every state and the debug port settles before the LOAD sample edge.
  assign debug_rf_ra = idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      hi_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hi_q <= range_hi;
            idx  <= lo_eff;
            // An inverted range produces no beats, only the done pulse.
            if (lo_eff > range_hi) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          out_data  <= debug_rf_rd;
          out_idx   <= idx;
          out_last  <= (idx == hi_q);
          out_valid <= 1'b1;
          state     <= SEND;
        end

        // Beat registers are only rewritten in LOAD, so they hold while
        // the sink stalls.
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // hi_q <= 31 means the last beat always precedes overflow;
              // the guard just keeps idx from ever wrapping.
              if (idx != RF_LAST_IDX) begin
                idx <= idx + RF_IDX_W'(1);
              end
              state <= LOAD;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
